dmem_responder: RTL
===================

Name: dmem_responder

Overview:
Data-memory responder for the pipelined LEGv8 core. It sits on the data-memory side of the CPU's load/store interface and services one doubleword request at a time. Each transaction uses a valid/ready request handshake, a fixed access latency, and a valid/ready response handshake. The CPU-side pipeline uses req_ready to stall.

Parameters:
DEPTH, 64, number of 64-bit words in the storage array.
IDX_W, 6, word-index width; must equal log2(DEPTH).
LATENCY, 2, cycles from request accept to resp_valid assertion; legal range 1-15.

Ports:
CLOCK  input  1  system clock; all logic is rising-edge.
RESET  input  1  synchronous, active-low reset.
req_valid  input  1  CPU presents a request.
req_ready  output  1  responder can accept a request (high only in IDLE).
mem_address  input  64  byte address; the word index is mem_address[IDX_W+2:3].
mem_data_in  input  64  write data.
control_memwrite  input  1  write request.
control_memread  input  1  read request.
resp_valid  output  1  response available.
resp_ready  input  1  CPU accepts the response.
mem_data_out  output  64  response data.
resp_error  output  1  address fault flag, qualified by resp_valid.

Behaviour:
- Reset (RESET low at a rising edge):
  - state becomes IDLE; req_ready=0 while RESET is low; resp_valid=0, mem_data_out=0, resp_error=0.
  - all DEPTH words cleared to 0.
  - req_ready=1 on the first cycle after RESET returns high.
- Accept condition: req_valid & req_ready & (control_memwrite | control_memread).
  - At accept, address, data, write flag and read flag are latched.
  - A request with both flags low is ignored: no state change, no response.
- States:
  - IDLE: req_ready=1. On accept, go to WAIT, or to RESP directly if LATENCY=1. The counter loads LATENCY-1.
  - WAIT: req_ready=0. The counter decrements each cycle. On the edge where the counter reaches 1, go to RESP.
  - RESP: resp_valid=1, req_ready=0. Outputs hold stable until resp_ready=1. On resp_ready=1 go to IDLE, so req_ready=1 on the next cycle.
- Timing:
  - Accept at edge N gives resp_valid high in cycle N+LATENCY.
  - Back-to-back throughput is one transaction per LATENCY+1 cycles at best.
- Array access on the edge entering RESP:
  - mem_data_out captures the stored word at the index.
  - If the write flag is set, the latched data is written at that same edge.
  - Read-before-write: a write response returns the old word. When both flags are set, the request acts as a write and returns the old data.
- mem_data_out holds its last value after the response until the next RESP entry.
- Reset mid-transaction drops the pending request. No write is committed unless RESP was already entered.
- resp_ready is ignored outside RESP.
- Request inputs are ignored outside IDLE.

Optional Feature:
Macro DMEM_ERR_EN.
- Defined: an address fault is mem_address[2:0]!=0 (misaligned) or mem_address[63:IDX_W+3]!=0 (out of range).
  - A faulting request still runs the full latency.
  - In RESP: resp_error=1, mem_data_out=0, and no write.
- Undefined: the low 3 bits and the upper bits are ignored, so addresses alias modulo DEPTH*8. resp_error is tied to 0.

Test Plan:
1. Reset, then write 0x1122334455667788 to address 0x10, then read 0x10 (LATENCY=2, resp_ready=1) -> each resp_valid arrives 2 cycles after accept. The write returns 0; the read returns 0x1122334455667788.
2. Preload 0x5 at address 0x18, then request with both flags set and data 0x9 -> response data 0x5; a following read of 0x18 returns 0x9.
3. Hold resp_ready low for 3 cycles during RESP -> resp_valid and mem_data_out stay stable and req_ready=0. Raise resp_ready -> req_ready=1 on the next cycle. A req_valid during RESP is not accepted.
4. Accept a write of 0xABCD to 0x08 (LATENCY=3), drive RESET low on accept+1 -> resp_valid never asserts; a read of 0x08 after reset returns 0.
5. With DMEM_ERR_EN: write to 0x0C and to 0x200 -> resp_error=1 and data 0 for both; index 1 and index 0 are unchanged. Without the macro: 0x0C writes index 1 and 0x200 writes index 0.
6. LATENCY=1, address 0x1F8 (index 63) write then read -> resp_valid in the cycle after accept, and the read returns the written value.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the pipelined LEGv8 core.
// Services one 64-bit doubleword request at a time. Each request is accepted with a
// valid/ready handshake, waits a fixed LATENCY, and is then answered with a valid/ready
// response handshake. The array is read and, for writes, updated on the edge that enters
// RESP, so a write returns the previous contents of the word.
//
// Ports:
//   CLOCK            rising-edge system clock
//   RESET            synchronous, active-low reset
//   req_valid        CPU presents a request
//   req_ready        responder idle and able to accept (low while RESET is low)
//   mem_address      byte address; word index is mem_address[IDX_W+2:3]
//   mem_data_in      write data
//   control_memwrite write request flag
//   control_memread  read request flag
//   resp_valid       response available (RESP state)
//   resp_ready       CPU accepts the response
//   mem_data_out     response data, held until the next response
//   resp_error       address fault flag, qualified by resp_valid
//
// Build option: define DMEM_ERR_EN to flag misaligned or out-of-range addresses. Faulting
// requests still take the full latency, return 0 with resp_error=1, and never write.
// Without it the low 3 and upper address bits are ignored and resp_error is tied low.

module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned IDX_W   = 6,
  parameter int unsigned LATENCY = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] mem_address,
  input  logic [63:0] mem_data_in,
  input  logic        control_memwrite,
  input  logic        control_memread,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] mem_data_out,
  output logic        resp_error
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       r_state;
  logic [3:0]       r_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [63:0]      r_data;
  logic             r_wr;
  logic             r_fault;
  logic [63:0]      r_dout;
  logic             r_err;
  logic [63:0]      r_mem [DEPTH];

  logic             w_idle;
  logic             w_accept;
  logic             w_enter_resp;
  logic [IDX_W-1:0] w_in_idx;
  logic             w_in_fault;
  logic [IDX_W-1:0] w_acc_idx;
  logic [63:0]      w_acc_data;
  logic             w_acc_wr;
  logic             w_acc_fault;

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle & RESET;
  assign w_accept  = req_valid & req_ready & (control_memwrite | control_memread);
  assign w_in_idx  = mem_address[IDX_W+2:3];

`ifdef DMEM_ERR_EN
  assign w_in_fault = (mem_address[2:0] != 3'd0) || (mem_address[63:IDX_W+3] != '0);
`else
  logic w_unused_addr;
  assign w_in_fault    = 1'b0;
  assign w_unused_addr = ^{mem_address[2:0], mem_address[63:IDX_W+3]};
`endif

  // With LATENCY=1 the array is accessed on the accept edge itself, so the request fields
  // come straight from the inputs; otherwise they come from the latched copies.
  assign w_acc_idx   = w_idle ? w_in_idx         : r_idx;
  assign w_acc_data  = w_idle ? mem_data_in      : r_data;
  assign w_acc_wr    = w_idle ? control_memwrite : r_wr;
  assign w_acc_fault = w_idle ? w_in_fault       : r_fault;

  assign w_enter_resp = (w_accept && (LATENCY == 1)) ||
                        ((r_state == S_WAIT) && (r_cnt == 4'd1));

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_idx   <= '0;
      r_data  <= 64'd0;
      r_wr    <= 1'b0;
      r_fault <= 1'b0;
      r_dout  <= 64'd0;
      r_err   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= 64'd0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_idx   <= w_in_idx;
            r_data  <= mem_data_in;
            r_wr    <= control_memwrite;
            r_fault <= w_in_fault;
            r_cnt   <= 4'(LATENCY - 1);
            r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Read-before-write: the old word is captured on the same edge the new one lands.
      if (w_enter_resp) begin
        r_dout <= w_acc_fault ? 64'd0 : r_mem[w_acc_idx];
        r_err  <= w_acc_fault;
        if (w_acc_wr && !w_acc_fault) begin
          r_mem[w_acc_idx] <= w_acc_data;
        end
      end
    end
  end

  assign resp_valid   = (r_state == S_RESP);
  assign mem_data_out = r_dout;

`ifdef DMEM_ERR_EN
  assign resp_error = r_err & resp_valid;
`else
  logic w_unused_err;
  assign w_unused_err = r_err;
  assign resp_error   = 1'b0;
`endif

endmodule
